// File: rtl/onehot_encoder_rr.sv
// onehot_encoder_rr
//   Collects one-cycle request pulses into a pending vector and hands them out
//   one index per cycle, in round-robin order, over a valid/ready interface.
//
// Ports
//   clk      in  1   rising-edge clock
//   rst_n    in  1   asynchronous active-low reset
//   D        in  N   request pulses, bit i = one request for index i (multi-hot ok)
//   I        out W   granted index (registered)
//   valid    out 1   I holds a granted index (registered)
//   ready    in  1   consumer takes I when valid && ready at a rising edge
//   pend     out N   pending-request vector (registered)
//   ovf      out 1   sticky overflow: a request arrived for an already pending index
//   ovf_clr  in  1   synchronous clear of ovf (a coincident new overflow wins)
module onehot_encoder_rr #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] D,
  output logic [W-1:0] I,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pend,
  output logic         ovf,
  input  logic         ovf_clr
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state;
  logic [W-1:0] ptr;

  logic [N-1:0] cand;
  logic [W-1:0] sel;
  logic         load;
  logic [N-1:0] load_mask;
  logic         ovf_set;
  logic [W-1:0] idx;

  // Candidates for this edge. While holding, nothing moves unless the consumer
  // takes I; the index being accepted is excluded so a re-request for it that
  // arrived during service waits for a later round instead of repeating now.
  always_comb begin
    cand = '0;
    if (state == IDLE) begin
      cand = pend;
    end else if (ready) begin
      cand = pend & ~(ONE << I);
    end
  end

  // Round-robin pick: first candidate scanning upward from ptr. W-bit
  // arithmetic wraps N-1 -> 0 on its own because N is a power of two.
  always_comb begin
    sel  = '0;
    load = 1'b0;
    idx  = '0;
    for (int j = 0; j < N; j++) begin
      idx = ptr + W'(j);
      if (!load && cand[idx]) begin
        load = 1'b1;
        sel  = idx;
      end
    end
  end

  always_comb begin
    load_mask = '0;
    if (load) begin
      load_mask = ONE << sel;
    end
    // A pulse on an index that is pending and not being loaded now is lost.
    ovf_set = |(D & pend & ~load_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      I     <= '0;
      valid <= 1'b0;
      ptr   <= '0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      // New pulses are OR-ed in after the loaded bit is cleared, so a request
      // arriving on the very edge its index is granted stays pending.
      pend <= (pend & ~load_mask) | D;
      ovf  <= ovf_set | (ovf & ~ovf_clr);
      case (state)
        IDLE: begin
          if (load) begin
            I     <= sel;
            ptr   <= sel + W'(1);
            valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (load) begin
            I     <= sel;
            ptr   <= sel + W'(1);
            valid <= 1'b1;
          end else if (ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_encoder_rr.sv
// tb_onehot_encoder_rr
//   Directed bench for onehot_encoder_rr (N=4). Expected grant indices are
//   pushed into a queue when requests are issued; a monitor pops and compares
//   on every valid&&ready handshake. Pend/valid/ovf are checked inline.
module tb_onehot_encoder_rr;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] D;
  logic [W-1:0] I;
  logic         valid;
  logic         ready;
  logic [N-1:0] pend;
  logic         ovf;
  logic         ovf_clr;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  onehot_encoder_rr #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .D(D), .I(I), .valid(valid),
    .ready(ready), .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_I", I, 0);
    #2;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: inputs are stable around the falling edge, so a
  // handshake seen here is the one the next rising edge completes.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got I=%0d expected no grant", I);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (I !== e) begin
          errors++;
          $display("FAIL grant_index: got I=%0d expected %0d", I, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; D = '0; ready = 1'b0; ovf_clr = 1'b0;
    #3;
    chk("por_valid", valid, 0);
    chk("por_pend", pend, 0);
    chk("por_ovf", ovf, 0);
    #4;
    rst_n = 1'b1;
    tick();

    // Single request, index 2.
    ready = 1'b1;
    D = 4'b0100;
    exp_q.push_back(2);
    tick();
    chk("single_pend", pend, 4'b0100);
    chk("single_valid0", valid, 0);
    D = '0;
    tick();
    chk("single_valid", valid, 1);
    chk("single_I", I, 2);
    chk("single_pend_clr", pend, 0);
    tick();
    chk("single_idle", valid, 0);
    chk("single_pend_end", pend, 0);

    // Round-robin over all four from ptr=0.
    do_reset();
    ready = 1'b1;
    D = 4'b1111;
    for (int k = 0; k < 4; k++) exp_q.push_back(W'(k));
    tick();
    chk("rr_pend", pend, 4'b1111);
    D = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_valid", valid, 1);
      chk("rr_I", I, k);
    end
    tick();
    chk("rr_idle", valid, 0);
    chk("rr_ovf", ovf, 0);

    // Back-pressure: index 0 held while ready=0, then index 1.
    do_reset();
    ready = 1'b0;
    D = 4'b0011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    tick();
    D = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", valid, 1);
      chk("bp_I", I, 0);
      chk("bp_pend", pend, 4'b0010);
      tick();
    end
    ready = 1'b1;
    tick();
    chk("bp_next_valid", valid, 1);
    chk("bp_next_I", I, 1);
    tick();
    chk("bp_idle", valid, 0);

    // Overflow: pend[1] already set, repeated pulse on D[1] while output is blocked.
    do_reset();
    ready = 1'b0;
    D = 4'b0001;
    exp_q.push_back(0);
    exp_q.push_back(1);
    tick();
    D = '0;
    tick();
    chk("ovf_hold_I", I, 0);
    D = 4'b0010;
    tick();
    D = '0;
    chk("ovf_pend1", pend, 4'b0010);
    chk("ovf_none_yet", ovf, 0);
    tick();
    D = 4'b0010;
    tick();
    D = '0;
    chk("ovf_set", ovf, 1);
    chk("ovf_pend_same", pend, 4'b0010);
    chk("ovf_I_same", I, 0);
    tick();
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    ovf_clr = 1'b1;
    D = 4'b0010;
    tick();
    ovf_clr = 1'b0;
    D = '0;
    chk("ovf_set_wins", ovf, 1);
    chk("ovf_valid_same", valid, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared2", ovf, 0);
    ready = 1'b1;
    tick();
    chk("ovf_drain_I", I, 1);
    tick();
    chk("ovf_drain_idle", valid, 0);
    chk("ovf_drain_pend", pend, 0);

    // Re-request of index 0 on the edge it is loaded.
    do_reset();
    ready = 1'b1;
    D = 4'b0001;
    exp_q.push_back(0);
    exp_q.push_back(0);
    tick();
    tick();
    D = '0;
    chk("rereq_valid", valid, 1);
    chk("rereq_I", I, 0);
    chk("rereq_pend", pend, 4'b0001);
    chk("rereq_ovf", ovf, 0);
    tick();
    chk("rereq_gap", valid, 0);
    chk("rereq_pend_kept", pend, 4'b0001);
    tick();
    chk("rereq_again_valid", valid, 1);
    chk("rereq_again_I", I, 0);
    chk("rereq_pend_clr", pend, 0);
    tick();
    chk("rereq_idle", valid, 0);

    // Asynchronous reset in the middle of a hold.
    do_reset();
    ready = 1'b0;
    D = 4'b0011;
    tick();
    D = '0;
    tick();
    D = 4'b0010;
    tick();
    D = '0;
    chk("ar_valid_pre", valid, 1);
    chk("ar_ovf_pre", ovf, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", valid, 0);
    chk("ar_pend", pend, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_I", I, 0);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ar_no_grant", valid, 0);
    end
    // Request sampled on the first edge after release is honoured.
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    D = 4'b0100;
    exp_q.push_back(2);
    tick();
    D = '0;
    chk("rel_pend", pend, 4'b0100);
    tick();
    chk("rel_valid", valid, 1);
    chk("rel_I", I, 2);
    tick();
    chk("rel_idle", valid, 0);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_rr.md
ONEHOT_ENCODER_RR -- requirements
Module: onehot_encoder_rr

Interface
REQ-001 SHALL have parameter N, default 4: number of request lines; power of two, 2..16.
REQ-002 SHALL derive W = log2(N), width of the encoded index (W=2 at default).
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port D, input, N: request lines, bit i high for one cycle = one request for index i; multi-hot permitted.
REQ-006 SHALL have port I, output, W: encoded index of the granted request, registered.
REQ-007 SHALL have port valid, output, 1: I holds a granted index, registered.
REQ-008 SHALL have port ready, input, 1: consumer accepts I when valid&&ready at a rising edge.
REQ-009 SHALL have port pend, output, N: pending-request vector, registered.
REQ-010 SHALL have port ovf, output, 1: sticky overflow flag, registered.
REQ-011 SHALL have port ovf_clr, input, 1: synchronous clear of ovf.

Function
REQ-012 SHALL set pend[i] at the rising edge where D[i]=1.
REQ-013 SHALL clear pend[i] at the edge where index i is loaded into I; D[i]=1 at that same edge SHALL leave pend[i]=1 (request not lost).
REQ-014 SHALL implement two states: IDLE (valid=0) and HOLD (valid=1).
REQ-015 IDLE: if pend!=0 at an edge, SHALL load I with the selected index, set valid, go HOLD; else stay IDLE.
REQ-016 HOLD: I and valid SHALL remain stable while ready=0.
REQ-017 HOLD with ready=1: if pend (excluding the index just accepted) !=0, SHALL load the next selected index at that same edge and stay HOLD (one grant per cycle); else SHALL clear valid and go IDLE.
REQ-018 Selection SHALL be round-robin: first set bit of pend scanning upward from ptr, wrapping N-1 -> 0.
REQ-019 ptr SHALL update to (loaded index + 1) mod N on every load; unchanged otherwise.
REQ-020 Selection SHALL use registered pend only; D at edge k is visible to selection no earlier than edge k+1.
REQ-021 Latency: D[i] at edge k with output free and no competitors -> valid=1, I=i after edge k+1.
REQ-022 ovf SHALL set at an edge where D[i]=1 and pend[i]=1 and i is not loaded at that edge.
REQ-023 ovf_clr=1 SHALL clear ovf at the edge; simultaneous set condition SHALL win (ovf stays 1).
REQ-024 pend, I, valid SHALL not be affected by ovf or ovf_clr.

Reset
REQ-025 rst_n=0 SHALL immediately force pend=0, I=0, valid=0, ovf=0, ptr=0, state IDLE, independent of clk.
REQ-026 Reset asserted mid-HOLD SHALL drop valid and discard all pending requests; no grant after release until new D.
REQ-027 After rst_n rises, first state update SHALL occur at the next rising clk edge; D sampled at that edge is honoured.

Verification
REQ-028 Single: reset, ready=1, D=4'b0100 one cycle -> pend=4'b0100 next cycle, then valid=1, I=2, then valid=0, pend=0.
REQ-029 Round-robin: ready=1, D=4'b1111 one cycle, ptr=0 -> I sequence 0,1,2,3 on consecutive cycles, valid=1 four cycles, ovf=0.
REQ-030 Back-pressure: ready=0, D=4'b0011 -> valid=1, I=0 held stable 5 cycles; ready=1 -> I=1 next cycle, then IDLE.
REQ-031 Overflow: ready=0, D=4'b0010 twice, 2 cycles apart, while pend[1]=1 -> ovf=1; ovf_clr pulse -> ovf=0; clr coincident with new overflow -> ovf=1.
REQ-032 Re-request at service: D[0]=1 at the edge index 0 is loaded -> pend[0]=1 remains, ovf=0, index 0 granted again after round-robin.
REQ-033 Async reset: rst_n=0 mid-HOLD between edges -> valid=0, pend=0, ovf=0 without clock edge; no spurious grant after release.
